uart_rx_frame_ctrl: RTL and testbench

Parametrised UART receive controller that merges start detection, majority-vote oversampling, bit/edge counting, deserialisation, parity and stop checking into one block. It sits between the RX pin synchroniser and the register/FIFO interface and supersedes the fixed 8-bit receive FSM. The data width is a parameter. Parity, parity type, stop-bit count and prescale are run-time configurable and latched per frame. It adds two-stop-bit checking and break detection.

---
 rtl/uart_rx_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive controller with start validation, 3-sample
// majority voting, LSB-first deserialisation, parity/stop checking and break
// detection. Frame configuration is captured when a start bit is first seen.
module uart_rx_frame_ctrl #(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic [PRESC_W-1:0] Prescale,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   input  logic               STOP2,
   output logic [DATA_W-1:0]  P_DATA,
   output logic               data_valid,
   output logic               par_err,
   output logic               stp_err,
   output logic               strt_glitch,
   output logic               brk_det,
   output logic               busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BRK_WAIT
   } state_t;

   state_t state, next_state;

   // per-frame configuration snapshot
   logic [PRESC_W-1:0] Prescale_l;
   logic               PAR_EN_l, PAR_TYP_l, STOP2_l;

   logic [PRESC_W-1:0] edge_cnt, mid;
   logic [CNT_W-1:0]   bit_cnt;
   logic [1:0]         smp;
   logic [DATA_W-1:0]  shreg;
   logic               par_fail, stp_fail, all_zero, brk_flag;

   logic maj, at_lo, at_mid, at_hi, bit_end, last_data, last_stop;
   logic stop_low, brk_hit, stp_fail_nx, brk_nx, frame_end;

   assign mid       = Prescale_l >> 1;
   assign at_lo     = (edge_cnt == mid - PRESC_W'(1));
   assign at_mid    = (edge_cnt == mid);
   assign at_hi     = (edge_cnt == mid + PRESC_W'(1));
   assign bit_end   = (edge_cnt == Prescale_l - PRESC_W'(1));
   assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));
   assign last_stop = (bit_cnt == CNT_W'(STOP2_l));

   // third sample taken live so the vote resolves on the mid+1 edge itself
   assign maj = (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);

   // with Prescale=4 the last vote lands on the final edge of the stop bit,
   // so the end-of-frame decision uses the forwarded fail/break values
   assign stop_low    = (state == STOP) && at_hi && !maj;
   assign brk_hit     = stop_low && (bit_cnt == '0) && all_zero;
   assign stp_fail_nx = stp_fail | stop_low;
   assign brk_nx      = brk_flag | brk_hit;

   assign busy = (state != IDLE);

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   // next-state logic and end-of-frame strobe
   always_comb begin
      next_state = state;
      frame_end  = 1'b0;
      case (state)
         IDLE:     if (!RX_IN) next_state = START;
         START: begin
            if (strt_glitch)          next_state = IDLE;
            else if (at_hi && maj)    next_state = START;
            else if (bit_end)         next_state = DATA;
         end
         DATA:     if (bit_end && last_data) next_state = PAR_EN_l ? PARITY : STOP;
         PARITY:   if (bit_end) next_state = STOP;
         STOP: begin
            if (bit_end && last_stop) begin
               frame_end  = 1'b1;
               next_state = brk_nx ? BRK_WAIT : IDLE;
            end
         end
         BRK_WAIT: if (RX_IN) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // counters, sampling, deserialiser, frame checks and result pulses
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Prescale_l  <= '0;
         PAR_EN_l    <= 1'b0;
         PAR_TYP_l   <= 1'b0;
         STOP2_l     <= 1'b0;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         smp         <= '0;
         shreg       <= '0;
         par_fail    <= 1'b0;
         stp_fail    <= 1'b0;
         all_zero    <= 1'b0;
         brk_flag    <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
         brk_det     <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
         brk_det     <= 1'b0;

         if (state == IDLE) begin
            bit_cnt <= '0;
            if (!RX_IN) begin
               // the detecting cycle is edge 0 of the start bit
               edge_cnt   <= PRESC_W'(1);
               Prescale_l <= Prescale;
               PAR_EN_l   <= PAR_EN;
               PAR_TYP_l  <= PAR_TYP;
               STOP2_l    <= STOP2;
               par_fail   <= 1'b0;
               stp_fail   <= 1'b0;
               all_zero   <= 1'b1;
               brk_flag   <= 1'b0;
            end else begin
               edge_cnt <= '0;
            end
         end else if (state == BRK_WAIT) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
         end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
            if (at_lo)  smp[0] <= RX_IN;
            if (at_mid) smp[1] <= RX_IN;

            case (state)
               START: if (at_hi && maj && !strt_glitch) strt_glitch <= 1'b1;
               DATA: begin
                  if (at_hi) begin
                     shreg <= {maj, shreg[DATA_W-1:1]};
                     if (maj) all_zero <= 1'b0;
                  end
                  if (bit_end) bit_cnt <= last_data ? '0 : bit_cnt + CNT_W'(1);
               end
               PARITY: begin
                  if (at_hi) begin
                     if (maj != ((^shreg) ^ PAR_TYP_l)) par_fail <= 1'b1;
                     if (maj) all_zero <= 1'b0;
                  end
               end
               STOP: begin
                  if (stop_low) stp_fail <= 1'b1;
                  if (brk_hit)  brk_flag <= 1'b1;
                  if (bit_end)  bit_cnt  <= last_stop ? '0 : bit_cnt + CNT_W'(1);
               end
               default: ;
            endcase

            // break outranks framing/parity errors; errors suppress the data
            if (frame_end) begin
               if (brk_nx) begin
                  brk_det <= 1'b1;
               end else if (par_fail || stp_fail_nx) begin
                  par_err <= par_fail;
                  stp_err <= stp_fail_nx;
               end else begin
                  data_valid <= 1'b1;
                  P_DATA     <= shreg;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frames are driven bit by bit on the
// falling clock edge, a monitor logs every result pulse with its cycle, and
// each scenario compares counts, cycles and data against hand-derived values.
module tb_uart_rx_frame_ctrl;

   localparam int DATA_W  = 8;
   localparam int PRESC_W = 6;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               RX_IN = 1'b1;
   logic [PRESC_W-1:0] Prescale;
   logic               PAR_EN, PAR_TYP, STOP2;
   logic [DATA_W-1:0]  P_DATA;
   logic               data_valid, par_err, stp_err, strt_glitch, brk_det, busy;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, t0 = 0, t1 = 0;
   int c_dv = 0, c_pe = 0, c_se = 0, c_sg = 0, c_bk = 0, c_ovl = 0;
   int y_dv = 0, y_pe = 0, y_se = 0, y_sg = 0, y_bk = 0;
   int                q_cyc[$];
   logic [DATA_W-1:0] q_dat[$];

   uart_rx_frame_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
      .stp_err(stp_err), .strt_glitch(strt_glitch), .brk_det(brk_det),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   // cycle index: value seen on a falling edge is the current cycle number
   always @(posedge CLK) cyc <= cyc + 1;

   // pulse logger
   always @(negedge CLK) begin
      if (data_valid) begin
         c_dv++; y_dv = cyc;
         q_cyc.push_back(cyc); q_dat.push_back(P_DATA);
      end
      if (par_err)     begin c_pe++; y_pe = cyc; end
      if (stp_err)     begin c_se++; y_se = cyc; end
      if (strt_glitch) begin c_sg++; y_sg = cyc; end
      if (brk_det)     begin c_bk++; y_bk = cyc; end
      if (data_valid && (par_err || stp_err || brk_det)) c_ovl++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      c_dv = 0; c_pe = 0; c_se = 0; c_sg = 0; c_bk = 0;
      q_cyc.delete(); q_dat.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_to(input int k);
      while (cyc - t0 < k) @(negedge CLK);
   endtask

   // drive one frame from the current falling edge; t0 = cycle 0 of the frame.
   // chg_bit >= 0 pulls Prescale to 16 at that bit and restores it 6 bits later.
   task automatic send_frame(input logic [DATA_W-1:0] d, input int presc,
                             input bit par_flip, input bit stop2_low, input int chg_bit);
      logic b[$];
      b.push_back(1'b0);
      for (int i = 0; i < DATA_W; i++) b.push_back(d[i]);
      if (PAR_EN) b.push_back((^d) ^ PAR_TYP ^ par_flip);
      b.push_back(1'b1);
      if (STOP2) b.push_back(!stop2_low);
      t0 = cyc;
      for (int i = 0; i < b.size(); i++) begin
         if (chg_bit >= 0 && i == chg_bit)     Prescale = PRESC_W'(16);
         if (chg_bit >= 0 && i == chg_bit + 6) Prescale = PRESC_W'(presc);
         RX_IN = b[i];
         repeat (presc) @(negedge CLK);
      end
      RX_IN = 1'b1;
   endtask

   initial begin
      Prescale = PRESC_W'(8); PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
      idle(3);
      // reset state
      chk("rst_pdata", P_DATA, 0);
      chk("rst_dv",    data_valid, 0);
      chk("rst_pulses", {par_err, stp_err, strt_glitch, brk_det}, 0);
      chk("rst_busy",  busy, 0);
      RST = 1'b0;
      idle(5);
      chk("idle_busy", busy, 0);

      // 0xA5, even parity bit 0, N = 11*8 = 88
      clr(); send_frame(8'hA5, 8, 1'b0, 1'b0, -1); idle(4);
      chk("s1_dv_cnt", c_dv, 1);
      chk("s1_dv_cyc", y_dv - t0, 88);
      chk("s1_pdata",  P_DATA, 8'hA5);
      chk("s1_errs",   c_pe + c_se + c_sg + c_bk, 0);
      chk("s1_busy_after", busy, 0);

      // same frame, parity bit flipped
      clr(); send_frame(8'hA5, 8, 1'b1, 1'b0, -1); idle(4);
      chk("s2_pe_cnt", c_pe, 1);
      chk("s2_pe_cyc", y_pe - t0, 88);
      chk("s2_dv_cnt", c_dv, 0);
      chk("s2_pdata",  P_DATA, 8'hA5);
      chk("s2_other",  c_se + c_bk, 0);

      // Prescale 16, no parity, two stops: N = 11*16 = 176
      Prescale = PRESC_W'(16); PAR_EN = 1'b0; STOP2 = 1'b1; idle(2);
      clr(); send_frame(8'h3C, 16, 1'b0, 1'b0, -1); idle(4);
      chk("s3a_dv_cnt", c_dv, 1);
      chk("s3a_dv_cyc", y_dv - t0, 176);
      chk("s3a_pdata",  P_DATA, 8'h3C);
      clr(); send_frame(8'h81, 16, 1'b0, 1'b1, -1); idle(4);
      chk("s3b_se_cnt", c_se, 1);
      chk("s3b_se_cyc", y_se - t0, 176);
      chk("s3b_dv_cnt", c_dv, 0);
      chk("s3b_pdata",  P_DATA, 8'h3C);
      chk("s3b_other",  c_pe + c_bk, 0);

      // 3-cycle low glitch at Prescale 16: votes at edges 7,8,9 all high
      clr(); t0 = cyc; RX_IN = 1'b0;
      idle(1);
      chk("s4_busy_c1", busy, 1);
      idle(2); RX_IN = 1'b1;
      wait_to(10);
      chk("s4_busy_c10", busy, 1);
      idle(1);
      chk("s4_busy_c11", busy, 0);
      idle(20);
      chk("s4_sg_cnt", c_sg, 1);
      chk("s4_sg_cyc", y_sg - t0, 10);
      chk("s4_other",  c_dv + c_pe + c_se + c_bk, 0);

      // break: low for 30 bit times at Prescale 8 with parity (N = 88)
      Prescale = PRESC_W'(8); PAR_EN = 1'b1; STOP2 = 1'b0; idle(2);
      clr(); t0 = cyc; RX_IN = 1'b0;
      wait_to(239);
      chk("s5_busy_c239", busy, 1);
      wait_to(240); RX_IN = 1'b1;
      chk("s5_busy_c240", busy, 1);
      idle(1);
      chk("s5_busy_c241", busy, 0);
      idle(10);
      chk("s5_bk_cnt", c_bk, 1);
      chk("s5_bk_cyc", y_bk - t0, 88);
      chk("s5_other",  c_dv + c_se + c_pe, 0);

      // back-to-back 0x55, 0xAA at Prescale 8, Prescale disturbed mid-frame one
      PAR_EN = 1'b0; idle(2);
      clr();
      send_frame(8'h55, 8, 1'b0, 1'b0, 3); t1 = t0;
      send_frame(8'hAA, 8, 1'b0, 1'b0, -1); idle(4);
      chk("s6_dv_cnt", c_dv, 2);
      chk("s6_dv0_cyc", (q_cyc.size() > 0) ? q_cyc[0] - t1 : -1, 80);
      chk("s6_dv_gap",  (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1, 80);
      chk("s6_dat0",    (q_dat.size() > 0) ? q_dat[0] : 8'h00, 8'h55);
      chk("s6_dat1",    (q_dat.size() > 1) ? q_dat[1] : 8'h00, 8'hAA);

      // third frame cut by reset mid data
      clr(); t0 = cyc; RX_IN = 1'b0;
      idle(30);
      RST = 1'b1; RX_IN = 1'b1;
      idle(2);
      chk("s6_rst_busy", busy, 0);
      RST = 1'b0;
      idle(100);
      chk("s6_rst_pulses", c_dv + c_pe + c_se + c_sg + c_bk, 0);
      chk("s6_rst_pdata",  P_DATA, 0);
      chk("s6_rst_outs",   {data_valid, par_err, stp_err, strt_glitch, brk_det, busy}, 0);

      chk("no_overlap", c_ovl, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
